// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory request at a time
// and presents the fetched word (or a NOP bubble) to the IF/ID register.
//
// state | meaning
// ------+----------------------------------------------------------------
// FETCH | request outstanding at req_addr; its response will be used
// VALID | inst_buf holds the instruction at pc; no request outstanding
// DROP  | request at req_addr still outstanding but redirected; discard it
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_en,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_f,
   output logic [31:0] pcplus4f,
   output logic [31:0] pc_f,
   output logic        fetch_stall
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      VALID = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] inst_buf_q, inst_buf_d;

   logic [31:0] target;
   logic [31:0] pc_inc;
   logic        unused_redirect_lsbs;

   assign target               = {redirect_pc[31:2], 2'b00};
   assign pc_inc               = pc_q + 32'd4;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         inst_buf_q <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         inst_buf_q <= inst_buf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      inst_buf_d = inst_buf_q;
      case (state_q)
         FETCH: begin
            if (redirect) begin
               pc_d = target;
               // A response landing with the redirect retires the old request, so the
               // new target can be issued at once; otherwise wait it out in DROP.
               if (imem_ready) begin
                  req_addr_d = target;
               end else begin
                  state_d = DROP;
               end
            end else if (imem_ready) begin
               inst_buf_d = imem_rdata;
               state_d    = VALID;
            end
         end
         VALID: begin
            if (redirect) begin
               pc_d       = target;
               req_addr_d = target;
               state_d    = FETCH;
            end else if (pc_en) begin
               pc_d       = pc_inc;
               req_addr_d = pc_inc;
               state_d    = FETCH;
            end
         end
         DROP: begin
            if (redirect) begin
               pc_d = target;
            end
            if (imem_ready) begin
               req_addr_d = redirect ? target : pc_q;
               state_d    = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_comb begin
      imem_req    = (state_q != VALID);
      imem_addr   = req_addr_q;
      fetch_stall = (state_q != VALID);
      inst_f      = (state_q == VALID) ? inst_buf_q : 32'h0000_0000;
      pc_f        = pc_q;
      pcplus4f    = pc_inc;
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_en;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] inst_f;
   logic [31:0] pcplus4f;
   logic [31:0] pc_f;
   logic        fetch_stall;

   int n_vec  = 0;
   int n_miss = 0;

   if_fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_en       (pc_en),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .inst_f      (inst_f),
      .pcplus4f    (pcplus4f),
      .pc_f        (pc_f),
      .fetch_stall (fetch_stall)
   );

   always #5 clk = ~clk;

   // Reference model: the fetch unit either holds an instruction, or has one request
   // in flight whose answer is wanted unless a redirect has made it stale.
   logic [31:0] m_pc, m_req, m_inst;
   logic        m_have, m_stale;

   task automatic model_reset();
      m_pc = RST_PC; m_req = RST_PC; m_inst = 32'h0; m_have = 1'b0; m_stale = 1'b0;
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      tgt = redirect_pc & 32'hFFFF_FFFC;
      if (m_have) begin
         if (redirect) begin
            m_pc = tgt; m_req = tgt; m_have = 1'b0;
         end else if (pc_en) begin
            m_pc = m_pc + 32'd4; m_req = m_pc; m_have = 1'b0;
         end
      end else if (redirect) begin
         m_pc = tgt;
         if (imem_ready) begin
            m_req = tgt; m_stale = 1'b0;
         end else begin
            m_stale = 1'b1;
         end
      end else if (imem_ready) begin
         if (m_stale) begin
            m_req = m_pc; m_stale = 1'b0;
         end else begin
            m_have = 1'b1; m_inst = imem_rdata;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic [31:0] e_inst, input logic [31:0] e_pc, input logic e_stall);
      chk({tag, ".imem_req"},    {31'h0, imem_req},    {31'h0, e_req});
      chk({tag, ".imem_addr"},   imem_addr,            e_addr);
      chk({tag, ".inst_f"},      inst_f,               e_inst);
      chk({tag, ".pc_f"},        pc_f,                 e_pc);
      chk({tag, ".pcplus4f"},    pcplus4f,             e_pc + 32'd4);
      chk({tag, ".fetch_stall"}, {31'h0, fetch_stall}, {31'h0, e_stall});
   endtask

   task automatic chk_model(input string tag);
      chk_out(tag, !m_have, m_req, m_have ? m_inst : 32'h0, m_pc, !m_have);
   endtask

   // Drive inputs at the falling edge, let one rising edge pass, return at the next fall.
   task automatic cyc(input logic en, input logic rd, input logic [31:0] rpc,
                      input logic rdy, input logic [31:0] rdat);
      pc_en = en; redirect = rd; redirect_pc = rpc; imem_ready = rdy; imem_rdata = rdat;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      model_reset();
      #1;
      chk_out(tag, 1'b1, RST_PC, 32'h0, RST_PC, 1'b1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        en;
      logic        rd;
      logic [31:0] rpc;
      logic        rdy;
      logic [31:0] rdat;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic        e_stall;
   } vec_t;

   vec_t tbl[16];

   initial begin
      //          en  rd  rpc           rdy rdata          req addr          inst          pc            stall
      tbl[0]  = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0000,32'h0,        32'h0000_0000,1'b1};
      tbl[1]  = '{1'b1,1'b0,32'h0,        1'b1,32'h2008_0005,1'b0,32'h0000_0000,32'h2008_0005,32'h0000_0000,1'b0};
      tbl[2]  = '{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0004,32'h0,        32'h0000_0004,1'b1};
      tbl[3]  = '{1'b0,1'b0,32'h0,        1'b1,32'h1111_1111,1'b0,32'h0000_0004,32'h1111_1111,32'h0000_0004,1'b0};
      tbl[4]  = '{1'b0,1'b0,32'h0,        1'b1,32'h9999_9999,1'b0,32'h0000_0004,32'h1111_1111,32'h0000_0004,1'b0};
      tbl[5]  = '{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0008,32'h0,        32'h0000_0008,1'b1};
      tbl[6]  = '{1'b0,1'b1,32'h0000_0043,1'b1,32'hAAAA_AAAA,1'b1,32'h0000_0040,32'h0,        32'h0000_0040,1'b1};
      tbl[7]  = '{1'b0,1'b1,32'h0000_0103,1'b0,32'h0,        1'b1,32'h0000_0040,32'h0,        32'h0000_0100,1'b1};
      tbl[8]  = '{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0040,32'h0,        32'h0000_0100,1'b1};
      tbl[9]  = '{1'b0,1'b1,32'h0000_0202,1'b0,32'h0,        1'b1,32'h0000_0040,32'h0,        32'h0000_0200,1'b1};
      tbl[10] = '{1'b0,1'b0,32'h0,        1'b1,32'hDEAD_BEEF,1'b1,32'h0000_0200,32'h0,        32'h0000_0200,1'b1};
      tbl[11] = '{1'b0,1'b0,32'h0,        1'b1,32'h1234_5678,1'b0,32'h0000_0200,32'h1234_5678,32'h0000_0200,1'b0};
      tbl[12] = '{1'b1,1'b1,32'h0000_0300,1'b0,32'h0,        1'b1,32'h0000_0300,32'h0,        32'h0000_0300,1'b1};
      tbl[13] = '{1'b0,1'b1,32'h0000_0404,1'b0,32'h0,        1'b1,32'h0000_0300,32'h0,        32'h0000_0404,1'b1};
      tbl[14] = '{1'b0,1'b1,32'h0000_050B,1'b1,32'h5555_5555,1'b1,32'h0000_0508,32'h0,        32'h0000_0508,1'b1};
      tbl[15] = '{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0000_0508,32'h0,        32'h0000_0508,1'b1};

      rst = 1'b1; pc_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_ready = 1'b0; imem_rdata = 32'h0;
      model_reset();
      #2;
      chk_out("reset", 1'b1, RST_PC, 32'h0, RST_PC, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].en, tbl[i].rd, tbl[i].rpc, tbl[i].rdy, tbl[i].rdat);
         chk_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_inst,
                 tbl[i].e_pc, tbl[i].e_stall);
      end

      // Stall in VALID at 0x10
      cyc(1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hA5A5_A5A5);
      chk_out("stall_entry", 1'b0, 32'h10, 32'hA5A5_A5A5, 32'h10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         chk_out($sformatf("stall_hold%0d", i), 1'b0, 32'h10, 32'hA5A5_A5A5, 32'h10, 1'b0);
      end

      // Redirect during a slow fetch at 0x20: drain old request, then fetch 0x100
      cyc(1'b0, 1'b1, 32'h0000_0020, 1'b0, 32'h0);
      chk_out("slow_fetch", 1'b1, 32'h20, 32'h0, 32'h20, 1'b1);
      cyc(1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
      chk_out("drop_c1", 1'b1, 32'h20, 32'h0, 32'h100, 1'b1);
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_out("drop_c2", 1'b1, 32'h20, 32'h0, 32'h100, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBADB_AD00);
      chk_out("drop_done", 1'b1, 32'h100, 32'h0, 32'h100, 1'b1);

      // Redirect coinciding with ready at 0x24
      cyc(1'b0, 1'b1, 32'h0000_0024, 1'b1, 32'h0);
      chk_out("at_0x24", 1'b1, 32'h24, 32'h0, 32'h24, 1'b1);
      cyc(1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'hCAFE_F00D);
      chk_out("redir_ready", 1'b1, 32'h40, 32'h0, 32'h40, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
      chk_out("after_redir", 1'b0, 32'h40, 32'h13, 32'h40, 1'b0);

      // PC wrap at the top of the address space
      cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0055);
      chk_out("wrap_valid", 1'b0, 32'hFFFF_FFFC, 32'h55, 32'hFFFF_FFFC, 1'b0);
      chk("wrap_pcplus4f", pcplus4f, 32'h0000_0000);
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_out("wrap_next", 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);

      // Reset while in DROP
      cyc(1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0);
      chk_out("pre_rst_drop", 1'b1, 32'h0, 32'h0, 32'h80, 1'b1);
      pulse_reset("rst_in_drop");
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0077);
      chk_out("post_rst_fetch", 1'b0, RST_PC, 32'h77, RST_PC, 1'b0);

      // Randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            pulse_reset($sformatf("rnd_rst%0d", i));
         end else begin
            cyc(1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0),
                $urandom,
                (!m_have && ($urandom_range(0, 9) < 4)),
                $urandom);
            chk_model($sformatf("rnd%0d", i));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port pc_en, input, 1 bit, hazard-unit write enable; 0 holds the PC (stall).
REQ-005 SHALL have port redirect, input, 1 bit, taken branch or jump from ID this cycle.
REQ-006 SHALL have port redirect_pc, input, 32 bits, target for redirect; bits [1:0] forced to 00.
REQ-007 SHALL have port imem_req, output, 1 bit, instruction-memory request.
REQ-008 SHALL have port imem_addr, output, 32 bits, word-aligned fetch address.
REQ-009 SHALL have port imem_ready, input, 1 bit, memory completion strobe; imem_rdata valid in the same cycle.
REQ-010 SHALL have port imem_rdata, input, 32 bits, fetched instruction.
REQ-011 SHALL have port inst_f, output, 32 bits, instruction to IF_ID.
REQ-012 SHALL have port pcplus4f, output, 32 bits, PC+4 of the instruction on inst_f.
REQ-013 SHALL have port pc_f, output, 32 bits, current PC.
REQ-014 SHALL have port fetch_stall, output, 1 bit, high when no valid instruction is presented.

Function
REQ-015 SHALL implement an FSM with states FETCH, VALID and DROP.
REQ-016 In FETCH: imem_req=1, imem_addr=req_addr. req_addr SHALL be a register, equal to pc when FETCH is entered, and SHALL stay stable until imem_ready.
REQ-017 FETCH with imem_ready and no redirect: capture imem_rdata into inst_buf, then go to VALID.
REQ-018 In VALID: imem_req=0, inst_f=inst_buf, fetch_stall=0.
REQ-019 In any state other than VALID: inst_f=32'h0000_0000 (NOP bubble), fetch_stall=1.
REQ-020 pcplus4f SHALL equal pc+4, computed modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-021 VALID with pc_en=1 and no redirect: pc <= pc+4, req_addr <= pc+4, go to FETCH.
REQ-022 VALID with pc_en=0 and no redirect: hold pc, inst_buf and state.
REQ-023 redirect SHALL have priority over pc_en.
REQ-024 pc_en SHALL be ignored in FETCH and DROP.
REQ-025 VALID with redirect: pc <= {redirect_pc[31:2],2'b00}, req_addr <= the same value, go to FETCH.
REQ-026 FETCH with redirect and imem_ready in the same cycle: discard imem_rdata, load pc and req_addr with the target, stay in FETCH.
REQ-027 FETCH with redirect and no imem_ready: load pc with the target, keep req_addr, go to DROP.
REQ-028 In DROP: imem_req=1, imem_addr=req_addr (the old address). On imem_ready, discard the data, set req_addr <= pc, go to FETCH.
REQ-029 Redirect in DROP: update pc to the newest target and stay in DROP; if imem_ready arrives in the same cycle, go to FETCH with req_addr equal to the new target.
REQ-030 At most one memory request SHALL be outstanding; a discarded response SHALL never reach inst_f.

Reset
REQ-031 While rst=1, asynchronously: pc=RESET_PC, req_addr=RESET_PC, inst_buf=0, state=FETCH.
REQ-032 Reset values of outputs: imem_req=1, imem_addr=RESET_PC, inst_f=0, pcplus4f=RESET_PC+4, pc_f=RESET_PC, fetch_stall=1.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction; a later imem_ready for it is not expected by the block.

Verification
REQ-034 Reset release, memory returns 0x2008_0005 one cycle after the request, pc_en=1 -> inst_f=0x2008_0005 with pcplus4f=0x0000_0004; next imem_addr=0x0000_0004.
REQ-035 VALID at pc=0x10, pc_en=0 for 3 cycles -> inst_f, pc_f=0x10 and state held; imem_req=0 throughout.
REQ-036 FETCH at 0x20 with imem_ready delayed 3 cycles, redirect to 0x0000_0103 in cycle 1 -> DROP, imem_addr stays 0x20 until ready; its data is discarded; next request goes to 0x100.
REQ-037 Redirect to 0x40 in the same cycle as imem_ready at 0x24 -> data discarded, next imem_addr=0x40, fetch_stall stays 1.
REQ-038 pc=0xFFFF_FFFC in VALID with pc_en=1 -> pcplus4f=0x0, next imem_addr=0x0.
REQ-039 rst pulsed while in DROP -> immediately pc_f=RESET_PC, inst_f=0, state FETCH.
